pi_level_encoder: RTL
=====================

PI_LEVEL_ENCODER -- requirements
Module: pi_level_encoder

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset; synchronous, active-low.
REQ-003 pi_on  in  1  global enable; low blocks new offers.
REQ-004 req  in  [0:7]  level requests; bit 0 is the highest priority; sampled every edge.
REQ-005 clear  in  [0:7]  dismiss-held pulses, one bit per level.
REQ-006 ack  in  1  consumer accepts the current offer.
REQ-007 en  out  1  offer valid; registered.
REQ-008 sel  out  [0:2]  offered level number, with 0 the highest priority; registered.
REQ-009 held  out  [0:7]  levels granted and not yet cleared; registered.
REQ-010 pend  out  [0:7]  latched, not-yet-granted requests; registered.

Function
REQ-011 pend[L] SHALL set on any edge where req[L]=1; pend is sticky until L is granted.
REQ-012 A grant of L SHALL occur on an edge where state=OFFER, ack=1 and sel=L.
REQ-013 On a grant, pend[L] SHALL clear and held[L] SHALL set.
REQ-014 req[L]=1 on the same edge as a grant of L SHALL leave pend[L]=1: set wins.
REQ-015 held[L] next value SHALL be (held[L] AND NOT clear[L]) OR grant[L]: grant wins over a simultaneous clear.
REQ-016 clear[L] with held[L]=0 SHALL have no effect.
REQ-017 Level L SHALL be eligible iff pend[L]=1 and held[k]=0 for all k<=L.
- Equal or higher priority in service blocks L.
- Eligibility uses registered pend and held only, never raw req.
REQ-018 The FSM SHALL have exactly two states, IDLE and OFFER.
REQ-019 IDLE SHALL transition to OFFER when pi_on=1 and any level is eligible.
- On that edge: sel <= lowest-numbered eligible L; en <= 1.
- Otherwise: stay IDLE, en=0, sel unchanged.
REQ-020 OFFER with ack=0 SHALL hold en=1 and keep sel stable, even if a higher-priority level becomes eligible or pi_on drops.
REQ-021 OFFER with ack=1 SHALL perform the grant, go to IDLE and drive en <= 0.
- This forces a minimum one-cycle en-low bubble between consecutive offers.
REQ-022 ack in IDLE SHALL be ignored.
REQ-023 Latency SHALL be fixed.
- req[L] sampled at edge N gives pend[L]=1 after edge N.
- en=1 with sel=L after edge N+1, provided the FSM is in IDLE, L is the top eligible level and pi_on=1.
REQ-024 After an ack at edge M, the next offer SHALL appear no earlier than after edge M+1.
REQ-025 Priority SHALL be strict by index with no rotation; the lowest-numbered eligible level always wins.
REQ-026 If all pending levels are blocked by held, the FSM SHALL remain in IDLE indefinitely with no timeout.

Reset
REQ-027 rst_n=0 at an edge SHALL force state=IDLE, en=0, sel=3'b000, pend=8'h00 and held=8'h00, overriding req, clear and ack on that edge.
REQ-028 Reset asserted during OFFER SHALL drop the offer without a grant; en=0 after that edge.
REQ-029 The first edge with rst_n=1 SHALL sample req normally.

Verification
REQ-030 Single request: req=8'b0010_0000 for one cycle at edge N, pi_on=1 -> en=1 and sel=2 after N+1; ack=1 at N+3 -> en=0, held=8'b0010_0000, pend=0 after N+3.
REQ-031 Priority pick and hold-off: req=8'b0001_0010 at edge N -> sel=3 offered; ack -> held[3]=1; level 6 stays blocked while held[3]=1.
- clear[3] pulse -> level 6 offered 2 edges later.
REQ-032 Stable offer and blocking: sel=5 offered, then req[1]=1 while ack=0 -> sel stays 5 until ack.
- Next offer is sel=1, after the bubble.
- Level 5 is now held, so no further offer occurs until clear[5].
REQ-033 Collisions: in OFFER with sel=4, drive ack=1, req[4]=1 and clear[4]=1 on the same edge -> pend[4]=1 and held[4]=1.
- No re-offer of level 4 occurs while held[4]=1.
REQ-034 Enable and reset: pi_on=0 with pend=8'hFF -> en stays 0.
- Set pi_on=1 -> sel=0 offered.
- rst_n=0 during that offer -> all outputs zero after the edge; the first edge with rst_n=1 samples req normally.

Source files
------------

// File: rtl/pi_level_encoder.sv
// Eight-level strict-priority request encoder: latches requests, offers the top
// eligible level through a two-state handshake and tracks granted-but-uncleared levels.
module pi_level_encoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pi_on,
    input  logic [0:7] req,
    input  logic [0:7] clear,
    input  logic       ack,
    output logic       en,
    output logic [0:2] sel,
    output logic [0:7] held,
    output logic [0:7] pend
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_OFFER = 1'b1;

    logic       state_q, state_d;
    logic [0:2] sel_q, sel_d;
    logic [0:7] pend_q, pend_d;
    logic [0:7] held_q, held_d;

    logic [0:7] grant;
    logic [0:7] elig;
    logic       any_elig;
    logic [0:2] pick;
    logic       blk;

    always_comb begin
        grant = '0;
        for (int l = 0; l < 8; l++) begin
            grant[l] = (state_q == ST_OFFER) && ack && (sel_q == 3'(l));
        end
    end

    // A level is blocked when it or any higher-priority level is still held.
    always_comb begin
        elig = '0;
        blk  = 1'b0;
        for (int l = 0; l < 8; l++) begin
            blk     = blk | held_q[l];
            elig[l] = pend_q[l] & ~blk;
        end
    end

    always_comb begin
        any_elig = 1'b0;
        pick     = 3'd0;
        for (int l = 7; l >= 0; l--) begin
            if (elig[l]) begin
                any_elig = 1'b1;
                pick     = 3'(l);
            end
        end
    end

    always_comb begin
        pend_d = req | (pend_q & ~grant);
        held_d = (held_q & ~clear) | grant;
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (pi_on && any_elig) begin
                    state_d = ST_OFFER;
                    sel_d   = pick;
                end
            end
            ST_OFFER: begin
                if (ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= 3'd0;
            pend_q  <= '0;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            pend_q  <= pend_d;
            held_q  <= held_d;
        end
    end

    assign en   = (state_q == ST_OFFER);
    assign sel  = sel_q;
    assign held = held_q;
    assign pend = pend_q;

endmodule
